conv_window_mac: RTL

Parametrised fixed-point multiply-accumulate engine for one convolution window. It computes the dot product of a TAPS-element image window and filter, adds a bias, then rounds, saturates and returns a DATA_W-bit result. It sits between the window line-buffer and the feature-map writer. It replaces the fixed 9-tap dot-product stage with one time-multiplexed multiplier and valid/ready handshakes on both sides.

---
 rtl/conv_mac_pkg.sv | 23 ++
 rtl/conv_round_sat.sv | 37 +++
 rtl/conv_window_mac.sv | 132 +++++++++++++
 3 files changed

// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg -- shared types and constants for the convolution-window MAC.
//   state_t   : engine FSM states (IDLE, MAC, NORM, DONE)
//   acc_w()   : accumulator width that cannot overflow for a given data width / tap count
//   DEF_*     : default Q-format and window size (Q8.8, 9 taps)
package conv_mac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      NORM,
      DONE
   } state_t;

   localparam int DEF_TAPS   = 9;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 8;

   // Full-precision products plus growth for TAPS additions plus one bit for the bias.
   function automatic int acc_w(input int data_w, input int taps);
      return 2 * data_w + $clog2(taps) + 1;
   endfunction

endpackage

// File: rtl/conv_round_sat.sv
// conv_round_sat -- combinational round-half-up and saturate of a wide accumulator.
//   acc    in  ACC_W   signed accumulator, 2*FRAC_W fractional bits
//   result out DATA_W  acc rounded to FRAC_W fractional bits, clamped to DATA_W signed range
//   sat    out 1       result was clamped
module conv_round_sat #(
   parameter int ACC_W  = 37,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [DATA_W-1:0] result,
   output logic                     sat
);

   // One extra bit so adding the rounding constant can never wrap.
   localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((1 << FRAC_W) >> 1);
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = ~MAXV;

   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] r;

   always_comb begin
      sum    = (ACC_W+1)'(acc) + RND;
      r      = sum >>> FRAC_W;
      sat    = 1'b0;
      result = r[DATA_W-1:0];
      if (r > MAXV) begin
         result = MAXV[DATA_W-1:0];
         sat    = 1'b1;
      end else if (r < MINV) begin
         result = MINV[DATA_W-1:0];
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac -- time-multiplexed fixed-point dot product of one convolution window.
// One multiplier walks TAPS pixel/weight pairs, adds the bias, then rounds and saturates
// to a DATA_W-bit Q(DATA_W-FRAC_W).FRAC_W result. Latency TAPS+1 cycles from accept.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  window handshake (img_win, filt_win, bias sampled on accept)
//   img_win, filt_win    TAPS packed signed elements, element i at [i*DATA_W +: DATA_W]
//   bias                 signed bias, same Q format as the result
//   out_valid/out_ready  result handshake; result and sat_flag held while stalled
//   result, sat_flag     rounded/saturated dot product and clamp indicator
//   busy                 engine is not idle
// Build option: define CONV_MAC_RELU_EN to force negative results to zero after
// saturation (sat_flag still reports the pre-ReLU clamp).
module conv_window_mac
   import conv_mac_pkg::*;
#(
   parameter int TAPS   = DEF_TAPS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [TAPS*DATA_W-1:0]   img_win,
   input  logic [TAPS*DATA_W-1:0]   filt_win,
   input  logic [DATA_W-1:0]        bias,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        result,
   output logic                     sat_flag,
   output logic                     busy
);

   localparam int ACC_W = acc_w(DATA_W, TAPS);
   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);

   state_t state, state_nxt;

   logic [TAPS*DATA_W-1:0]  img_r, filt_r;
   logic signed [ACC_W-1:0] acc;
   logic [IDX_W-1:0]        idx;

   logic signed [DATA_W-1:0]   pix, wgt;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    bias_ext;
   logic [DATA_W-1:0]          rs_result, norm_result;
   logic                       rs_sat;

   // The window registers shift down one element per MAC cycle, so the
   // multiplier always reads element 0 instead of a TAPS-way mux on idx.
   assign pix      = img_r[DATA_W-1:0];
   assign wgt      = filt_r[DATA_W-1:0];
   assign prod     = (2*DATA_W)'(pix) * (2*DATA_W)'(wgt);
   assign bias_ext = ACC_W'(signed'(bias)) <<< FRAC_W;

   conv_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_round_sat (
      .acc    (acc),
      .result (rs_result),
      .sat    (rs_sat)
   );

`ifdef CONV_MAC_RELU_EN
   assign norm_result = rs_result[DATA_W-1] ? '0 : rs_result;
`else
   assign norm_result = rs_result;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)         state_nxt = MAC;
         MAC:     if (idx == IDX_LAST)  state_nxt = NORM;
         NORM:                          state_nxt = DONE;
         DONE:    if (out_ready)        state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img_r    <= '0;
         filt_r   <= '0;
         acc      <= '0;
         idx      <= '0;
         result   <= '0;
         sat_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  img_r  <= img_win;
                  filt_r <= filt_win;
                  acc    <= bias_ext;
                  idx    <= '0;
               end
            end
            MAC: begin
               acc    <= acc + ACC_W'(prod);
               idx    <= idx + 1'b1;
               img_r  <= img_r >> DATA_W;
               filt_r <= filt_r >> DATA_W;
            end
            NORM: begin
               result   <= norm_result;
               sat_flag <= rs_sat;
            end
            default: ;
         endcase
      end
   end

endmodule
